// File: rtl/mmio_bridge.sv
// Memory/IO bridge for the cpu byte bus: decodes RAM vs the IO window and owns the UART
// tx FIFO, the free-running cycle counter and the program-stop sequence.
module mmio_bridge #(
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              program_stop
);

  typedef enum logic [1:0] {StRun, StDrain, StStopped} state_e;
  typedef enum logic [1:0] {SrcRam, SrcRx, SrcCnt, SrcZero} src_e;

  localparam int unsigned     CntW       = FIFO_AW + 1;
  localparam logic [CntW-1:0] Depth      = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AlmostFull = CntW'(FIFO_DEPTH - 1);

  logic            w_io, w_sel_rx, w_sel_cnt, w_stop_wr;
  logic [15:0]     w_off;
  logic            w_unused_addr;

  state_e          r_state, w_state_d;
  src_e            r_src, w_src_d;
  logic [7:0]      r_io_byte, w_io_byte_d;
  logic            r_rd_ok;
  logic [31:0]     r_cnt, r_snap;
  logic            w_snap_ld;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count, w_count_d;
  logic            r_full, r_stop;
  logic            w_push_req, w_push, w_pop, w_empty, w_fifo_full;
  logic [7:0]      w_push_data;

  assign w_io          = (cpu_a[17:16] == 2'b11);
  assign w_off         = cpu_a[15:0];
  assign w_sel_rx      = w_io && (w_off == 16'h0000);
  assign w_sel_cnt     = w_io && (w_off[15:2] == 14'h0001);
  assign w_stop_wr     = w_io && (w_off == 16'h0004);
  assign w_unused_addr = ^cpu_a[31:18];

  assign ram_a     = cpu_a[RAM_AW-1:0];
  assign ram_wr    = cpu_wr & ~w_io & ~rst_in;
  assign ram_wdata = cpu_dout;

  // Read request decode: the IO byte is captured now and returned next cycle.
  always_comb begin
    w_src_d     = SrcRam;
    w_io_byte_d = 8'h00;
    w_snap_ld   = 1'b0;
    rx_pop      = 1'b0;
    if (w_io) begin
      w_src_d = SrcZero;
      if (!cpu_wr && !rst_in) begin
        if (w_sel_rx) begin
          w_src_d = SrcRx;
          if (rx_valid) begin
            rx_pop      = 1'b1;
            w_io_byte_d = rx_data;
          end
        end else if (w_sel_cnt) begin
          w_src_d = SrcCnt;
          unique case (cpu_a[1:0])
            2'd0: begin
              w_io_byte_d = r_cnt[7:0];
              w_snap_ld   = 1'b1;
            end
            2'd1: w_io_byte_d = r_snap[15:8];
            2'd2: w_io_byte_d = r_snap[23:16];
            2'd3: w_io_byte_d = r_snap[31:24];
          endcase
        end
      end
    end
  end

  // Zero bytes on the data port are not characters; the stop write enqueues a 0x00 marker.
  assign w_push_req  = !rst_in && cpu_wr && (r_state == StRun) &&
                       ((w_sel_rx && (cpu_dout != 8'h00)) || w_stop_wr);
  assign w_push_data = w_stop_wr ? 8'h00 : cpu_dout;
  assign w_empty     = (r_count == '0);
  assign w_fifo_full = (r_count == Depth);
  assign w_pop       = !w_empty && tx_ready;
  assign w_push      = w_push_req && (!w_fifo_full || w_pop);
  assign w_count_d   = r_count + CntW'(w_push) - CntW'(w_pop);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:     if (!rst_in && cpu_wr && w_stop_wr) w_state_d = StDrain;
      StDrain:   if (w_empty && !w_push) w_state_d = StStopped;
      StStopped: w_state_d = StStopped;
      default:   w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= StRun;
      r_src     <= SrcRam;
      r_io_byte <= 8'h00;
      r_rd_ok   <= 1'b0;
      r_cnt     <= 32'h0;
      r_snap    <= 32'h0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_src     <= w_src_d;
      r_io_byte <= w_io_byte_d;
      r_rd_ok   <= 1'b1;
      r_cnt     <= r_cnt + 32'd1;
      if (w_snap_ld) r_snap <= r_cnt;
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
      r_count   <= w_count_d;
      r_full    <= (w_count_d >= AlmostFull);
      r_stop    <= (w_state_d == StStopped);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  // r_rd_ok masks the first response after reset so an in-flight read returns zero.
  assign cpu_din        = !r_rd_ok ? 8'h00 : ((r_src == SrcRam) ? ram_rdata : r_io_byte);
  assign tx_valid       = !w_empty;
  assign tx_data        = w_empty ? 8'h00 : r_mem[r_rptr];
  assign io_buffer_full = r_full;
  assign program_stop   = r_stop;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: a vector table for single-cycle behaviour plus hand-written
// sequences for the counter snapshot, FIFO fill/drain, stop sequence and mid-run reset.
module tb_mmio_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] cpu_a = 32'h0;
  logic [7:0]  cpu_dout = 8'h0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        program_stop;

  int n_cmp = 0;
  int n_fail = 0;

  mmio_bridge #(.RAM_AW(17), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  // 128KB synchronous RAM with 1-cycle read latency
  logic [7:0] ram [0:131071];
  always @(posedge clk_in) begin
    if (ram_wr) ram[ram_a] <= ram_wdata;
    ram_rdata <= ram[ram_a];
  end

  typedef struct {
    logic [31:0] a;
    logic [7:0]  dout;
    logic        wr;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        exp_ramwr;
    logic        exp_pop;
    logic        chk_din;
    logic [7:0]  exp_din;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] dout, input logic wr,
                              input logic rxv, input logic [7:0] rxd, input logic txr,
                              input logic exp_ramwr, input logic exp_pop, input logic chk_din,
                              input logic [7:0] exp_din, input logic exp_txv,
                              input logic [7:0] exp_txd);
    vec_t v;
    v.a = a; v.dout = dout; v.wr = wr; v.rxv = rxv; v.rxd = rxd; v.txr = txr;
    v.exp_ramwr = exp_ramwr; v.exp_pop = exp_pop; v.chk_din = chk_din; v.exp_din = exp_din;
    v.exp_txv = exp_txv; v.exp_txd = exp_txd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
    cpu_a = a; cpu_dout = d; cpu_wr = wr;
  endtask

  task automatic idle();
    drive(32'h0, 8'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
    drive(32'h5000, 8'hEE, 1'b1);
    #1 chk("reset ram_wr gated", ram_wr, 1'b0);
    step();
    drive(32'h30000, 8'h00, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h99;
    #1 chk("reset rx_pop gated", rx_pop, 1'b0);
    step();
    chk("reset cpu_din", cpu_din, 8'h00);
    chk("reset io_buffer_full", io_buffer_full, 1'b0);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset program_stop", program_stop, 1'b0);
    rst_in = 1'b0; rx_valid = 1'b0;
    idle();
  endtask

  vec_t vecs[17];
  logic [7:0] drain_exp [8];
  logic [7:0] stop_exp [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          addr         dout  wr rxv rxd   txr rwr pop cdin din  txv  txd
    vecs[0]  = mk(32'h01234, 8'hAB, 1, 0, 8'h00, 0,  1,  0,  0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(32'h01234, 8'h00, 0, 0, 8'h00, 0,  0,  0,  1, 8'hAB, 0, 8'h00);
    vecs[2]  = mk(32'h1FFFF, 8'h3C, 1, 0, 8'h00, 0,  1,  0,  0, 8'h00, 0, 8'h00);
    vecs[3]  = mk(32'h1FFFF, 8'h00, 0, 0, 8'h00, 0,  0,  0,  1, 8'h3C, 0, 8'h00);
    vecs[4]  = mk(32'h3FFFF, 8'h99, 1, 0, 8'h00, 0,  0,  0,  0, 8'h00, 0, 8'h00);
    vecs[5]  = mk(32'h1FFFF, 8'h00, 0, 0, 8'h00, 0,  0,  0,  1, 8'h3C, 0, 8'h00);
    vecs[6]  = mk(32'h30010, 8'h00, 0, 0, 8'h00, 0,  0,  0,  1, 8'h00, 0, 8'h00);
    vecs[7]  = mk(32'h30000, 8'h41, 1, 0, 8'h00, 1,  0,  0,  0, 8'h00, 1, 8'h41);
    vecs[8]  = mk(32'h30000, 8'h00, 1, 0, 8'h00, 1,  0,  0,  0, 8'h00, 0, 8'h00);
    vecs[9]  = mk(32'h30000, 8'h42, 1, 0, 8'h00, 1,  0,  0,  0, 8'h00, 1, 8'h42);
    vecs[10] = mk(32'h01234, 8'h00, 0, 0, 8'h00, 1,  0,  0,  1, 8'hAB, 0, 8'h00);
    vecs[11] = mk(32'h30000, 8'h00, 0, 1, 8'h5A, 0,  0,  1,  1, 8'h5A, 0, 8'h00);
    vecs[12] = mk(32'h30000, 8'h00, 0, 0, 8'h66, 0,  0,  0,  1, 8'h00, 0, 8'h00);
    vecs[13] = mk(32'h30000, 8'h00, 1, 1, 8'h77, 0,  0,  0,  0, 8'h00, 0, 8'h00);
    vecs[14] = mk(32'h30001, 8'h00, 0, 1, 8'h77, 0,  0,  0,  1, 8'h00, 0, 8'h00);
    vecs[15] = mk(32'h30008, 8'h77, 1, 0, 8'h00, 0,  0,  0,  0, 8'h00, 0, 8'h00);
    vecs[16] = mk(32'h30005, 8'h12, 1, 0, 8'h00, 0,  0,  0,  0, 8'h00, 0, 8'h00);

    do_reset();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].a, vecs[i].dout, vecs[i].wr);
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd; tx_ready = vecs[i].txr;
      #1;
      chk($sformatf("v%0d ram_wr", i), ram_wr, vecs[i].exp_ramwr);
      chk($sformatf("v%0d rx_pop", i), rx_pop, vecs[i].exp_pop);
      step();
      if (vecs[i].chk_din) chk($sformatf("v%0d cpu_din", i), cpu_din, vecs[i].exp_din);
      chk($sformatf("v%0d tx_valid", i), tx_valid, vecs[i].exp_txv);
      if (vecs[i].exp_txv) chk($sformatf("v%0d tx_data", i), tx_data, vecs[i].exp_txd);
    end
    idle(); rx_valid = 1'b0; tx_ready = 1'b0;

    // Counter snapshot: counter is k during the k-th cycle after reset release.
    do_reset();
    repeat (32'h1FF) step();
    drive(32'h30004, 8'h0, 1'b0); step(); chk("cnt byte0", cpu_din, 8'hFF);
    drive(32'h30005, 8'h0, 1'b0); step(); chk("cnt byte1 snap", cpu_din, 8'h01);
    drive(32'h30006, 8'h0, 1'b0); step(); chk("cnt byte2 snap", cpu_din, 8'h00);
    drive(32'h30007, 8'h0, 1'b0); step(); chk("cnt byte3 snap", cpu_din, 8'h00);
    drive(32'h30004, 8'h0, 1'b0); step(); chk("cnt reload byte0", cpu_din, 8'h03);
    drive(32'h30005, 8'h0, 1'b0); step(); chk("cnt reload byte1", cpu_din, 8'h02);
    idle();

    // FIFO fill with the UART stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h30000, 8'(8'h10 + i), 1'b1);
      step();
      chk($sformatf("fill%0d full", i), io_buffer_full, (i >= 6) ? 1'b1 : 1'b0);
    end
    chk("fill head", tx_data, 8'h10);
    // Push and pop together while full: count stays at depth.
    drive(32'h30000, 8'h19, 1'b1); tx_ready = 1'b1;
    step();
    chk("full push+pop full flag", io_buffer_full, 1'b1);
    idle();
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d tx_valid", k), tx_valid, 1'b1);
      chk($sformatf("drain%0d tx_data", k), tx_data, drain_exp[k]);
      step();
      chk($sformatf("drain%0d full", k), io_buffer_full, (k == 0) ? 1'b1 : 1'b0);
    end
    chk("drain empty", tx_valid, 1'b0);

    // Program stop: queued bytes plus the 0x00 marker must drain before program_stop.
    tx_ready = 1'b0;
    drive(32'h30000, 8'h61, 1'b1); step();
    drive(32'h30000, 8'h62, 1'b1); step();
    drive(32'h30004, 8'h55, 1'b1); step();
    chk("stop pending 0", program_stop, 1'b0);
    drive(32'h30000, 8'h63, 1'b1); step();
    idle(); step();
    chk("stop pending 1", program_stop, 1'b0);
    tx_ready = 1'b1;
    stop_exp = '{8'h61, 8'h62, 8'h00};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stop%0d tx_valid", k), tx_valid, 1'b1);
      chk($sformatf("stop%0d tx_data", k), tx_data, stop_exp[k]);
      chk($sformatf("stop%0d program_stop", k), program_stop, 1'b0);
      step();
    end
    chk("stop drained", tx_valid, 1'b0);
    for (int w = 0; w < 4 && !program_stop; w++) step();
    chk("program_stop asserted", program_stop, 1'b1);
    drive(32'h30000, 8'h70, 1'b1); step();
    chk("stopped write ignored", tx_valid, 1'b0);
    drive(32'h30004, 8'h00, 1'b1); step();
    chk("stopped stop-write ignored", tx_valid, 1'b0);
    drive(32'h02000, 8'h5C, 1'b1); step();
    drive(32'h02000, 8'h00, 1'b0); step();
    chk("stopped ram read", cpu_din, 8'h5C);
    chk("program_stop sticky", program_stop, 1'b1);
    idle();

    // Reset mid-operation with data queued and a read in flight.
    do_reset();
    drive(32'h30000, 8'h51, 1'b1); step();
    drive(32'h30000, 8'h52, 1'b1); step();
    chk("midrst queued", tx_valid, 1'b1);
    drive(32'h01234, 8'h00, 1'b0); rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("midrst in-flight din", cpu_din, 8'h00);
    chk("midrst fifo flushed", tx_valid, 1'b0);
    chk("midrst full", io_buffer_full, 1'b0);
    step();
    chk("midrst ram kept", cpu_din, 8'hAB);
    drive(32'h30004, 8'h00, 1'b0); step();
    chk("midrst counter cleared", cpu_din, 8'h01);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Memory/IO bridge directly downstream of the cpu top's byte-wide memory bus. Decodes each cpu bus cycle to either the 128KB RAM or the memory-mapped I/O window at mem_a[17:16]==2'b11. Owns the UART tx FIFO, which generates io_buffer_full, plus the free-running cycle counter and the program-stop sequence. Returns read data to the cpu exactly one cycle after the request.

Parameters:
RAM_AW, 17, RAM byte-address width.
FIFO_DEPTH, 8, tx FIFO entries; must be a power of 2 and at least 4.
FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
cpu_a  input  32  cpu address (mem_a)
cpu_dout  input  8  cpu write data (mem_dout)
cpu_wr  input  1  1 = write, 0 = read (mem_wr)
cpu_din  output  8  read data to cpu (mem_din), valid the cycle after the request
io_buffer_full  output  1  tx FIFO nearly full, registered
ram_a  output  RAM_AW  RAM address
ram_wr  output  1  RAM write enable
ram_wdata  output  8  RAM write data
ram_rdata  input  8  RAM read data, 1-cycle latency
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART accepts the byte this cycle
rx_data  input  8  UART received byte
rx_valid  input  1  rx_data available
rx_pop  output  1  consume rx_data, 1-cycle pulse
program_stop  output  1  sticky; program finished and tx drained

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset state: FIFO empty, counter 0, FSM RUN, src_q = RAM. All outputs are 0 (cpu_din, io_buffer_full, ram_wr, tx_valid, rx_pop, program_stop).
- Decode: io = (cpu_a[17:16]==2'b11). ram_a = cpu_a[RAM_AW-1:0] (combinational). ram_wr = cpu_wr & ~io & ~rst_in. ram_wdata = cpu_dout.
- Read return path:
  - A registered source select (RAM / RX / CNT / ZERO) and a registered IO byte are captured on each request.
  - cpu_din = ram_rdata when src_q is RAM, otherwise the registered IO byte.
  - Latency is exactly 1 cycle for every read.
- IO read 0x30000: if rx_valid, pulse rx_pop for 1 cycle and return rx_data next cycle; otherwise return 0x00 with no pop.
- IO read 0x30004-0x30007: return byte cpu_a[1:0] of a 32-bit counter snapshot.
  - A read at offset 0 loads the snapshot from the live counter.
  - Reads at offsets 1-3 use the held snapshot, so a 4-byte little-endian read is coherent.
- Cycle counter: increments every cycle after reset and wraps 0xFFFFFFFF -> 0.
- Other IO addresses: reads return 0x00; writes are ignored.
- IO write 0x30000 (FSM in RUN only):
  - Data != 0x00: push into the tx FIFO.
  - Data == 0x00: ignored.
  - Push while the FIFO is full: byte is dropped and the FIFO is unchanged.
- IO write 0x30004 in RUN: push 0x00 (dropped if the FIFO is full) and go to DRAIN.
- FSM:
  - RUN -> DRAIN on write to 0x30004.
  - DRAIN -> STOPPED when the FIFO is empty and no push is occurring.
  - STOPPED: program_stop=1 from the cycle after entry. All IO writes are ignored; RAM accesses still work.
  - STOPPED is left only by reset.
- tx FIFO:
  - tx_valid = non-empty; tx_data = head entry.
  - Pop on tx_valid & tx_ready.
  - Simultaneous push and pop at full: both take effect and the count is unchanged.
  - Simultaneous push and pop at empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; count is FIFO_AW+1 bits.
- io_buffer_full: registered, = (next_count >= FIFO_DEPTH-1). The one reserved slot covers the cpu reacting one cycle late.
- Reset mid-operation: FIFO contents discarded and counter cleared; any in-flight read returns 0x00 the next cycle.

Test Plan:
- Reset, then RAM write 0x1234 <- 0xAB, then read 0x1234 -> cpu_din=0xAB exactly 1 cycle after the read; ram_wr high only during the write cycle.
- Writes 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data 0x41 then 0x42; 0x00 never enqueued.
- tx_ready=0, write 7 bytes -> io_buffer_full=1 after the 7th write; 8th accepted, 9th dropped; raising tx_ready drains 8 bytes in order and io_buffer_full falls.
- Read 0x30004 at counter 0x000001FF, then 0x30005/6/7 over the next cycles -> bytes 0xFF, 0x01, 0x00, 0x00 (snapshot held).
- rx_valid=1, rx_data=0x5A, read 0x30000 -> rx_pop pulse, cpu_din=0x5A; with rx_valid=0 -> 0x00 and no pop.
- Two bytes queued with tx_ready=0, write to 0x30004 -> program_stop stays 0; enable tx_ready -> 0x.., 0x.., 0x00 sent, then program_stop=1; a later write to 0x30000 is ignored.
